// File: rtl/uram_capture128k.sv
// AXI-Stream to URAM capture stage: after arm/trigger, writes a programmable
// number of stream beats into the URAM through a BRAM_CTRL-style write port.
module uram_capture128k #(
    parameter int DWIDTH         = 128,
    parameter int MEM_SIZE_BYTES = 131072,
    localparam int DEPTH         = MEM_SIZE_BYTES / (DWIDTH / 8),
    localparam int URAM_AWIDTH   = $clog2(DEPTH)
) (
    input  logic                   axis_clk,
    input  logic                   axis_areset,
    input  logic [DWIDTH-1:0]      s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   arm,
    input  logic                   trigger,
    input  logic                   abort,
    input  logic [URAM_AWIDTH:0]   num_words,
    output logic                   busy,
    output logic                   done,
    output logic [URAM_AWIDTH:0]   words_written,
    output logic [DWIDTH-1:0]      portA_cpu_wdata,
    output logic [DWIDTH/8-1:0]    portA_we,
    output logic                   portA_en,
    input  logic [DWIDTH-1:0]      portA_cpu_rdata,
    output logic [31:0]            portAcpu_addr,
    output logic                   portA_clk,
    output logic                   portA_rst
);

    localparam int BYTES      = DWIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam logic [URAM_AWIDTH:0] DEPTH_W = (URAM_AWIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t                 state_reg;
    logic [URAM_AWIDTH:0]   len_reg;
    logic [URAM_AWIDTH:0]   words_reg;
    logic [URAM_AWIDTH:0]   words_next;
    logic [URAM_AWIDTH:0]   len_next;
    logic                   en_reg;
    logic [31:0]            addr_reg;
    logic [BYTES-1:0]       we_reg;
    logic [DWIDTH-1:0]      wdata_reg;
    logic                   capture_hs;
    logic                   unused_rdata;

    // Read data is never consumed; this is a write-only master.
    assign unused_rdata = ^portA_cpu_rdata;

    // tready comes straight from the state register: no input-to-output path.
    assign s_axis_tready = (state_reg == ST_ARMED) || (state_reg == ST_CAPTURE);
    assign busy          = s_axis_tready;
    assign done          = (state_reg == ST_DONE);
    assign words_written = words_reg;

    assign capture_hs = s_axis_tvalid && (state_reg == ST_CAPTURE);
    assign words_next = words_reg + 1'b1;

    // Zero or oversized requests fill the whole buffer.
    always_comb begin
        len_next = num_words;
        if ((num_words == '0) || (num_words > DEPTH_W)) begin
            len_next = DEPTH_W;
        end
    end

    always_ff @(posedge axis_clk or posedge axis_areset) begin
        if (axis_areset) begin
            state_reg <= ST_IDLE;
            len_reg   <= DEPTH_W;
            words_reg <= '0;
            en_reg    <= 1'b0;
            addr_reg  <= '0;
        end else begin
            en_reg <= capture_hs;
            if (capture_hs) begin
                addr_reg  <= 32'(words_reg) << BYTE_SHIFT;
                words_reg <= words_next;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (!abort && arm) begin
                        state_reg <= ST_ARMED;
                        len_reg   <= len_next;
                        words_reg <= '0;
                    end
                end
                ST_ARMED: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                    end else if (trigger) begin
                        state_reg <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // An aborted cycle still writes its beat (handled above).
                    if (abort) begin
                        state_reg <= ST_IDLE;
                    end else if (capture_hs && (words_next == len_reg)) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                    end else if (arm) begin
                        state_reg <= ST_ARMED;
                        len_reg   <= len_next;
                        words_reg <= '0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Per-byte-lane write data and enables, registered one cycle after the handshake.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        always_ff @(posedge axis_clk or posedge axis_areset) begin
            if (axis_areset) begin
                we_reg[gi]             <= 1'b0;
                wdata_reg[gi*8 +: 8]   <= '0;
            end else begin
                we_reg[gi] <= capture_hs;
                if (capture_hs) begin
                    wdata_reg[gi*8 +: 8] <= s_axis_tdata[gi*8 +: 8];
                end
            end
        end
    end

    assign portA_en        = en_reg;
    assign portA_we        = we_reg;
    assign portA_cpu_wdata = wdata_reg;
    assign portAcpu_addr   = addr_reg;
    assign portA_clk       = axis_clk;
    assign portA_rst       = axis_areset;

endmodule

// File: doc/uram_capture128k.md
Name: uram_capture128k

Overview:
- AXI-Stream-to-URAM capture stage that fills the 128-bit, 128 KiB URAM buffer later read out by the playback stage.
- Sits between the ADC/DDC sample stream and the URAM write port.
- Drives a BRAM_CTRL-style master port in write mode.
- Captures a programmable number of 128-bit beats after an arm/trigger sequence, then reports completion to the PS.

Parameters:
- DWIDTH, 128, stream and memory word width in bits; byte-enable width is DWIDTH/8.
- MEM_SIZE_BYTES, 131072, URAM size in bytes.
- DEPTH (localparam), MEM_SIZE_BYTES/(DWIDTH/8) = 8192, number of words.
- URAM_AWIDTH (localparam), $clog2(DEPTH) = 13, word-index width.

Ports:
- axis_clk  in  1  single clock for all logic; also drives portA_clk.
- axis_areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  DWIDTH  input sample beat.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted when high together with tvalid.
- arm  in  1  single-cycle request to arm a capture.
- trigger  in  1  starts capture while armed.
- abort  in  1  returns the block to IDLE from any state.
- num_words  in  URAM_AWIDTH+1  beats to capture, latched on arm; 0 or values >DEPTH mean DEPTH.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- words_written  out  URAM_AWIDTH+1  beats written in current/last capture.
- portA_cpu_wdata  out  DWIDTH  URAM write data.
- portA_we  out  DWIDTH/8  byte enables.
- portA_en  out  1  URAM enable.
- portA_cpu_rdata  in  DWIDTH  unused.
- portAcpu_addr  out  32  byte address.
- portA_clk  out  1  equals axis_clk.
- portA_rst  out  1  equals axis_areset.

Behaviour:
- Reset (async assert, sync release) drives all outputs to zero:
  - state=IDLE; s_axis_tready=0; busy=0; done=0; words_written=0.
  - portA_en=0, portA_we=0, portAcpu_addr=0, portA_cpu_wdata=0.
- States: IDLE, ARMED, CAPTURE, DONE. Only transitions listed here exist.
- s_axis_tready is decoded from the state register only (1 in ARMED and CAPTURE, else 0), so there is no combinational path from inputs.
- IDLE:
  - arm=1 → ARMED on the next edge; latch len (num_words, clamped as above) and clear words_written.
  - trigger is ignored.
- ARMED:
  - Beats are accepted and discarded, so there is no backpressure to the ADC.
  - trigger=1 → CAPTURE. The beat handshaked in the trigger cycle is discarded.
  - arm is ignored.
- CAPTURE:
  - Each handshake registers one write, issued the following cycle:
    - portA_en=1, portA_we=all ones, portA_cpu_wdata=beat.
    - portAcpu_addr = words_written*(DWIDTH/8), using the pre-increment count.
  - words_written increments on each handshake.
  - Cycles without a handshake: portA_en=0, portA_we=0.
  - Write latency is exactly 1 cycle from handshake to URAM write.
  - On the handshake that makes words_written==len → DONE on that edge. tready is 0 from the next cycle, so no extra beat is taken.
  - Address never exceeds (DEPTH-1)*16 = 0x1FFF0. There is no wrap.
- DONE:
  - done=1; the final write issues in the first DONE cycle.
  - Holds until arm=1 → ARMED (done cleared, new len latched, words_written cleared).
- abort=1 in any state → IDLE on the next edge. abort has priority over arm and trigger.
  - A beat handshaked in the abort cycle during CAPTURE is still written and counted.
  - words_written holds its value in IDLE.
  - done is cleared.
- Simultaneous events:
  - arm+trigger in IDLE → ARMED only.
  - Reset mid-capture immediately deasserts portA_en/we. Memory contents are undefined for the interrupted write.
- Outputs are insensitive to portA_cpu_rdata.

Test Plan:
- Reset then idle 10 cycles with tvalid=1 → tready=0, portA_en=0, busy=0, done=0, addr=0.
- num_words=4, arm, 3 cycles armed, trigger, 4 continuous beats D0..D3:
  - Writes appear 1 cycle after each handshake at addr 0x0,0x10,0x20,0x30, we=0xFFFF.
  - done=1 in the cycle after the D3 handshake; tready=0 while a 5th beat is held valid.
- num_words=0, arm, trigger, stream with tvalid toggling every other cycle → 8192 writes, last at 0x1FFF0, words_written=8192, done=1, no write on idle cycles.
- abort after 5 beats of num_words=100 → 5 writes at 0x0..0x40, state IDLE, done=0, words_written=5. A following trigger alone causes no writes.
- Re-arm from DONE with num_words=2 → done clears next cycle, words_written=0. After trigger, writes go to 0x0 and 0x10.
- Assert axis_areset mid-capture (asynchronously, between clock edges) → portA_en, tready and busy drop without waiting for an edge. After release, block is in IDLE with words_written=0.
